// File: rtl/usb_bridge_pkg.sv
// Shared types and constants for the USB EBI register bridge.
// FSM state encoding, register address width, error-clear key.
package usb_bridge_pkg;

  localparam int REG_AW = 6;

  localparam logic [REG_AW-1:0] ERR_CLR_ADDR = 6'h3F;
  localparam logic [7:0]        ERR_CLR_DATA = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_READY,
    S_RD,
    S_RDLAT,
    S_WR,
    S_RELEASE
  } state_t;

endpackage

// File: rtl/usb_reg_if.sv
// Register-side bus of the USB bridge.
// master = bridge, slave = register blocks.
interface usb_reg_if;
  import usb_bridge_pkg::*;

  logic [REG_AW-1:0] reg_address_o;
  logic [REG_AW-1:0] reg_hypaddress_o;
  logic [15:0]       reg_bytecnt_o;
  logic [7:0]        reg_datao_o;
  logic [7:0]        reg_datai_i;
  logic [15:0]       reg_hyplen_i;
  logic              reg_read_o;
  logic              reg_write_o;
  logic              reg_addrvalid_o;

  modport master (
    output reg_address_o,
    output reg_hypaddress_o,
    output reg_bytecnt_o,
    output reg_datao_o,
    output reg_read_o,
    output reg_write_o,
    output reg_addrvalid_o,
    input  reg_datai_i,
    input  reg_hyplen_i
  );

  modport slave (
    input  reg_address_o,
    input  reg_hypaddress_o,
    input  reg_bytecnt_o,
    input  reg_datao_o,
    input  reg_read_o,
    input  reg_write_o,
    input  reg_addrvalid_o,
    output reg_datai_i,
    output reg_hyplen_i
  );

endinterface

// File: rtl/usb_strobe_sync.sv
// Per-bit flop-chain synchronisers for the active-low EBI strobes.
// Chains reset to all-ones so strobes read as inactive.
module usb_strobe_sync #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_sync [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++)
        r_sync[i] <= '1;
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < STAGES; i++)
        r_sync[i] <= r_sync[i-1];
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/usb_reg_bridge.sv
// EBI (async strobe) to internal register bus bridge.
// Optional idle watchdog: define USB_BRIDGE_TIMEOUT_EN.
module usb_reg_bridge
  import usb_bridge_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       clk_usb,
  input  logic       reset_n,
  input  logic [7:0] USB_Addr,
  input  logic [7:0] USB_D_in,
  output logic [7:0] USB_D_out,
  output logic       USB_D_oe,
  input  logic       USB_RDn,
  input  logic       USB_WRn,
  input  logic       USB_CEn,
  input  logic       USB_ALEn,
  usb_reg_if.master  regs,
  output logic       err_o
);

  state_t r_state;
  state_t w_next;

  logic [3:0]        w_sync;
  logic              w_rd_n;
  logic              w_wr_n;
  logic              w_ce_n;
  logic              w_ale_n;
  logic              w_in_range;
  logic              w_timeout;
  logic              w_enter_addr;
  logic              w_err_set;
  logic              w_err_clr;
  logic              w_read;
  logic              w_write;
  logic [REG_AW-1:0] r_addr;
  logic [15:0]       r_bytecnt;
  logic [7:0]        r_datao;
  logic [7:0]        r_dout;
  logic              r_oe;
  logic              r_err;
  logic              r_addrvalid;
  logic              w_unused;

  usb_strobe_sync #(
    .STAGES(SYNC_STAGES),
    .WIDTH (4)
  ) u_sync (
    .clk  (clk_usb),
    .rst_n(reset_n),
    .i_d  ({USB_ALEn, USB_CEn, USB_WRn, USB_RDn}),
    .o_q  (w_sync)
  );

  assign w_rd_n  = w_sync[0];
  assign w_wr_n  = w_sync[1];
  assign w_ce_n  = w_sync[2];
  assign w_ale_n = w_sync[3];

  assign w_unused   = &{1'b0, USB_Addr[7:6]};
  assign w_in_range = r_bytecnt < regs.reg_hyplen_i;

`ifdef USB_BRIDGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_idle_cnt;
  logic          w_idle;

  assign w_idle    = (r_state == S_READY) &&
                     w_rd_n && w_wr_n && w_ale_n;
  assign w_timeout = w_idle &&
                     (r_idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n)
      r_idle_cnt <= '0;
    else if (w_idle && !w_timeout)
      r_idle_cnt <= r_idle_cnt + TW'(1);
    else
      r_idle_cnt <= '0;
  end
`else
  logic w_unused_to;

  assign w_unused_to = (TIMEOUT_CYCLES > 0);
  assign w_timeout   = 1'b0;
`endif

  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // Strobe-driven moves out of IDLE/READY all need chip enable.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (!w_ce_n && !w_ale_n) w_next = S_ADDR;
      S_ADDR:
        if (w_ale_n) w_next = S_READY;
      S_READY:
        if (w_timeout)              w_next = S_IDLE;
        else if (!w_ce_n) begin
          if (!w_rd_n && !w_wr_n)   w_next = S_RELEASE;
          else if (!w_rd_n)         w_next = S_RD;
          else if (!w_wr_n)         w_next = S_WR;
          else if (!w_ale_n)        w_next = S_ADDR;
        end
      S_RD:      w_next = S_RDLAT;
      S_RDLAT:   w_next = S_RELEASE;
      S_WR:      w_next = S_RELEASE;
      S_RELEASE:
        if (w_rd_n && w_wr_n) w_next = S_READY;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_read  = 1'b0;
    w_write = 1'b0;
    unique case (1'b1)
      (r_state == S_RD): w_read  = w_in_range;
      (r_state == S_WR): w_write = 1'b1;
      default: ;
    endcase
  end

  assign w_enter_addr = (w_next == S_ADDR) &&
                        (r_state != S_ADDR);
  assign w_err_set = ((r_state == S_READY) &&
                      (w_next == S_RELEASE)) ||
                     ((r_state == S_RDLAT) && !w_in_range) ||
                     w_timeout;
  assign w_err_clr = (r_state == S_WR) &&
                     (r_addr == ERR_CLR_ADDR) &&
                     (r_datao == ERR_CLR_DATA);

  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      r_addr      <= '0;
      r_bytecnt   <= '0;
      r_datao     <= '0;
      r_dout      <= '0;
      r_err       <= 1'b0;
      r_addrvalid <= 1'b0;
    end else begin
      if (w_enter_addr) begin
        r_addr      <= USB_Addr[REG_AW-1:0];
        r_bytecnt   <= '0;
        r_addrvalid <= 1'b1;
      end
      if (w_timeout)
        r_addrvalid <= 1'b0;
      if ((r_state == S_READY) && (w_next == S_WR))
        r_datao <= USB_D_in;
      if (r_state == S_RDLAT)
        r_dout <= w_in_range ? regs.reg_datai_i : 8'h00;
      if ((r_state == S_RELEASE) && (w_next == S_READY) &&
          (r_bytecnt != 16'hFFFF))
        r_bytecnt <= r_bytecnt + 16'd1;
      if (w_err_set)
        r_err <= 1'b1;
      else if (w_err_clr)
        r_err <= 1'b0;
    end
  end

  // Pad drive only while the host is still reading.
  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n)
      r_oe <= 1'b0;
    else if (r_state == S_RDLAT)
      r_oe <= w_wr_n && !w_rd_n && !w_ce_n;
    else if (w_rd_n || w_ce_n || !w_wr_n)
      r_oe <= 1'b0;
  end

  assign USB_D_out             = r_dout;
  assign USB_D_oe              = r_oe;
  assign err_o                 = r_err;
  assign regs.reg_address_o    = r_addr;
  assign regs.reg_hypaddress_o = r_addr;
  assign regs.reg_bytecnt_o    = r_bytecnt;
  assign regs.reg_datao_o      = r_datao;
  assign regs.reg_read_o       = w_read;
  assign regs.reg_write_o      = w_write;
  assign regs.reg_addrvalid_o  = r_addrvalid;

endmodule

// File: tb/tb_usb_reg_bridge.sv
// Directed bench for usb_reg_bridge.
// Build with USB_BRIDGE_TIMEOUT_EN to exercise the watchdog.
module tb_usb_reg_bridge;

  logic       clk;
  logic       reset_n;
  logic [7:0] USB_Addr;
  logic [7:0] USB_D_in;
  logic [7:0] USB_D_out;
  logic       USB_D_oe;
  logic       USB_RDn;
  logic       USB_WRn;
  logic       USB_CEn;
  logic       USB_ALEn;
  logic       err_o;

  int total = 0;
  int bad   = 0;
  int rd_cnt = 0;
  int n_wr;
  int n_rd;
  logic [15:0] wr_bc[$];
  logic [7:0]  wr_dat[$];
  logic [7:0]  d;

  usb_reg_if rif();

  usb_reg_bridge #(
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_usb  (clk),
    .reset_n  (reset_n),
    .USB_Addr (USB_Addr),
    .USB_D_in (USB_D_in),
    .USB_D_out(USB_D_out),
    .USB_D_oe (USB_D_oe),
    .USB_RDn  (USB_RDn),
    .USB_WRn  (USB_WRn),
    .USB_CEn  (USB_CEn),
    .USB_ALEn (USB_ALEn),
    .regs     (rif),
    .err_o    (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rif.reg_write_o) begin
      wr_bc.push_back(rif.reg_bytecnt_o);
      wr_dat.push_back(rif.reg_datao_o);
    end
    if (rif.reg_read_o)
      rd_cnt++;
  end

  task automatic chk(
    input string       t,
    input logic [31:0] o,
    input logic [31:0] e
  );
    total++;
    if (o !== e) begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h",
             t, o, e);
    end
  endtask

  task automatic ale(input logic [7:0] a);
    USB_Addr = a;
    USB_ALEn = 1'b0;
    repeat (4) @(negedge clk);
    USB_ALEn = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_write(input logic [7:0] v);
    USB_D_in = v;
    USB_WRn  = 1'b0;
    repeat (6) @(negedge clk);
    USB_WRn  = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic do_read(output logic [7:0] v);
    USB_RDn = 1'b0;
    repeat (8) @(negedge clk);
    v = USB_D_out;
    USB_RDn = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    reset_n  = 1'b0;
    USB_Addr = 8'h00;
    USB_D_in = 8'h00;
    USB_RDn  = 1'b1;
    USB_WRn  = 1'b1;
    USB_CEn  = 1'b1;
    USB_ALEn = 1'b1;
    rif.reg_datai_i  = 8'h00;
    rif.reg_hyplen_i = 16'hFFFF;
    repeat (3) @(negedge clk);
    chk("rst_valid", rif.reg_addrvalid_o, 1'b0);
    chk("rst_err",   err_o,               1'b0);
    chk("rst_oe",    USB_D_oe,            1'b0);
    chk("rst_wr",    rif.reg_write_o,     1'b0);
    chk("rst_rd",    rif.reg_read_o,      1'b0);
    reset_n = 1'b1;
    USB_CEn = 1'b0;
    repeat (3) @(negedge clk);

    // Scenario 1: three writes to 0x12, first one timed
    ale(8'h12);
    chk("s1_addr",  rif.reg_address_o,    6'h12);
    chk("s1_haddr", rif.reg_hypaddress_o, 6'h12);
    chk("s1_valid", rif.reg_addrvalid_o,  1'b1);
    chk("s1_bc0",   rif.reg_bytecnt_o,    16'h0000);
    USB_D_in = 8'hAA;
    USB_WRn  = 1'b0;
    repeat (2) @(negedge clk);
    chk("wr_lat_early", rif.reg_write_o, 1'b0);
    @(negedge clk);
    chk("wr_lat",       rif.reg_write_o, 1'b1);
    @(negedge clk);
    chk("wr_one_cycle", rif.reg_write_o, 1'b0);
    repeat (2) @(negedge clk);
    USB_WRn = 1'b1;
    repeat (6) @(negedge clk);
    do_write(8'hBB);
    do_write(8'hCC);
    chk("s1_nwr",  wr_bc.size(), 3);
    chk("s1_bc_0", wr_bc[0],  16'd0);
    chk("s1_bc_1", wr_bc[1],  16'd1);
    chk("s1_bc_2", wr_bc[2],  16'd2);
    chk("s1_d_0",  wr_dat[0], 8'hAA);
    chk("s1_d_1",  wr_dat[1], 8'hBB);
    chk("s1_d_2",  wr_dat[2], 8'hCC);
    chk("s1_bc_end", rif.reg_bytecnt_o, 16'd3);

    // Chip enable high blocks strobes, keeps address
    USB_CEn = 1'b1;
    do_write(8'h77);
    chk("ce_nwr",   wr_bc.size(),        3);
    chk("ce_valid", rif.reg_addrvalid_o, 1'b1);
    USB_CEn = 1'b0;
    repeat (4) @(negedge clk);

    // Scenario 2: reads with length 2
    rif.reg_hyplen_i = 16'd2;
    rif.reg_datai_i  = 8'h5C;
    ale(8'h05);
    n_rd = rd_cnt;
    USB_RDn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rd_pulse",   rif.reg_read_o, 1'b1);
    @(negedge clk);
    chk("rd_oe_early", USB_D_oe, 1'b0);
    @(negedge clk);
    chk("rd_lat_data", USB_D_out, 8'h5C);
    chk("rd_oe",       USB_D_oe,  1'b1);
    repeat (3) @(negedge clk);
    USB_RDn = 1'b1;
    repeat (6) @(negedge clk);
    chk("rd_oe_off", USB_D_oe, 1'b0);
    do_read(d);
    chk("s2_d1",    d,     8'h5C);
    chk("s2_err0",  err_o, 1'b0);
    rif.reg_datai_i = 8'h3C;
    do_read(d);
    chk("s2_d2",    d,     8'h00);
    chk("s2_nrd",   rd_cnt - n_rd, 2);
    chk("s2_err1",  err_o, 1'b1);

    // Scenario 3: collision, then error clear
    ale(8'h3F);
    n_wr = wr_bc.size();
    n_rd = rd_cnt;
    do_write(8'hA5);
    chk("s3_clr0",   err_o, 1'b0);
    chk("s3_fwd0",   wr_bc.size() - n_wr, 1);
    USB_RDn = 1'b0;
    USB_WRn = 1'b0;
    repeat (6) @(negedge clk);
    chk("s3_col_oe", USB_D_oe, 1'b0);
    USB_RDn = 1'b1;
    USB_WRn = 1'b1;
    repeat (6) @(negedge clk);
    chk("s3_col_wr",  wr_bc.size() - n_wr, 1);
    chk("s3_col_rd",  rd_cnt - n_rd, 0);
    chk("s3_col_err", err_o, 1'b1);
    do_write(8'h11);
    chk("s3_keep",   err_o, 1'b1);
    do_write(8'hA5);
    chk("s3_clr",    err_o, 1'b0);
    chk("s3_fwd_d",  wr_dat[wr_dat.size()-1], 8'hA5);
    chk("s3_fwd_n",  wr_bc.size() - n_wr, 3);

    // Scenario 4: reset between sync and pulse
    n_wr = wr_bc.size();
    n_rd = rd_cnt;
    USB_D_in = 8'h66;
    USB_WRn  = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("s4_rst_wr",    rif.reg_write_o,     1'b0);
    chk("s4_rst_valid", rif.reg_addrvalid_o, 1'b0);
    chk("s4_rst_bc",    rif.reg_bytecnt_o,   16'h0000);
    repeat (2) @(negedge clk);
    USB_WRn = 1'b1;
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("s4_nwr", wr_bc.size() - n_wr, 0);
    rif.reg_hyplen_i = 16'hFFFF;
    USB_RDn = 1'b0;
    repeat (6) @(negedge clk);
    chk("s4_oe", USB_D_oe, 1'b0);
    USB_RDn = 1'b1;
    repeat (6) @(negedge clk);
    chk("s4_nrd",   rd_cnt - n_rd, 0);
    chk("s4_valid", rif.reg_addrvalid_o, 1'b0);

    // Scenario 5: idle in READY
    ale(8'h20);
    chk("s5_valid0", rif.reg_addrvalid_o, 1'b1);
    repeat (20) @(negedge clk);
`ifdef USB_BRIDGE_TIMEOUT_EN
    chk("s5_to_valid", rif.reg_addrvalid_o, 1'b0);
    chk("s5_to_err",   err_o,               1'b1);
`else
    chk("s5_valid", rif.reg_addrvalid_o, 1'b1);
    chk("s5_err",   err_o,               1'b0);
`endif

    // Scenario 6: byte counter saturation
    ale(8'h01);
    chk("s6_bc0", rif.reg_bytecnt_o, 16'h0000);
    force dut.r_bytecnt = 16'hFFFD;
    @(negedge clk);
    release dut.r_bytecnt;
    @(negedge clk);
    n_wr = wr_bc.size();
    do_write(8'h01);
    do_write(8'h02);
    do_write(8'h03);
    chk("s6_bc_sat", rif.reg_bytecnt_o, 16'hFFFF);
    do_write(8'h04);
    chk("s6_n",      wr_bc.size() - n_wr, 4);
    chk("s6_p0",     wr_bc[n_wr],     16'hFFFD);
    chk("s6_p2",     wr_bc[n_wr + 2], 16'hFFFF);
    chk("s6_p3",     wr_bc[n_wr + 3], 16'hFFFF);
    chk("s6_hold",   rif.reg_bytecnt_o, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
